// File: rtl/mac_row4.sv
// mac_row4: four-tap FP16 transposed-form multiply-accumulate row with stationary weights.
// Build option MAC_ROW4_SUBNORM_EN enables gradual underflow; otherwise subnormals flush to signed zero.
module mac_row4 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enX,
    input  logic [3:0]  enW,
    input  logic [15:0] X_i,
    input  logic [15:0] W_i,
    output logic        valid_o,
    output logic [15:0] Y_o
);
    localparam int unsigned FILL_FULL = 4;
    localparam logic [15:0] QNAN      = 16'h7E00;
    localparam logic [14:0] INF_MAG   = 15'h7C00;

    logic [15:0] w0, w1, w2, w3;
    logic [15:0] s0, s1, s2, s3;
    logic [15:0] s0_nxt_c, s1_nxt_c, s2_nxt_c, s3_nxt_c;
    logic [2:0]  fc;

    function automatic logic is_nan(input logic [15:0] v);
        return (v[14:10] == 5'h1F) && (v[9:0] != 10'd0);
    endfunction

    function automatic logic is_inf(input logic [15:0] v);
        return (v[14:10] == 5'h1F) && (v[9:0] == 10'd0);
    endfunction

    // Significand with hidden bit and effective biased exponent: |v| = sig * 2^(e-25).
    function automatic void unpack(input logic [15:0] v, output logic [10:0] sig, output int e);
        if (v[14:10] == 5'd0) begin
`ifdef MAC_ROW4_SUBNORM_EN
            sig = {1'b0, v[9:0]};
`else
            sig = 11'd0;
`endif
            e = 1;
        end else begin
            sig = {1'b1, v[9:0]};
            e   = {27'd0, v[14:10]};
        end
    endfunction

    // Round-to-nearest-even of the exact nonzero magnitude m * 2^e into FP16.
    function automatic logic [15:0] round_pack(input logic sign, input logic [47:0] m, input int e);
        int          p;
        int          eb;
        int          lsb;
        logic [47:0] kept;
        logic [47:0] enc;
        logic        g;
        logic        st;
        p = 0;
        for (int i = 0; i < 48; i++) begin
            if (((m >> i) & 48'd1) != 48'd0) p = i;
        end
        eb = p + e + 15;
        if (eb >= 31) return {sign, INF_MAG};
        if (eb < 1) eb = 1;
        // Position of the kept LSB: either 10 below the leading one or the subnormal quantum.
        lsb = eb - 25 - e;
        if (lsb <= 0) begin
            kept = m << (-lsb);
            g    = 1'b0;
            st   = 1'b0;
        end else begin
            kept = m >> lsb;
            g    = ((m >> (lsb - 1)) & 48'd1) != 48'd0;
            st   = (m & ((48'd1 << (lsb - 1)) - 48'd1)) != 48'd0;
        end
        kept = kept + {47'd0, g & (st | kept[0])};
        // Hidden bit lands in the exponent field, so a rounding carry bumps the exponent.
        enc = (48'(eb - 1) << 10) + kept;
`ifndef MAC_ROW4_SUBNORM_EN
        if (enc < 48'h400) return {sign, 15'd0};
`endif
        if (enc >= 48'h7C00) return {sign, INF_MAG};
        return {sign, enc[14:0]};
    endfunction

    function automatic logic [15:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
        logic [10:0] ma, mb;
        int          ea, eb;
        logic        s;
        s = a[15] ^ b[15];
        unpack(a, ma, ea);
        unpack(b, mb, eb);
        if (is_nan(a) || is_nan(b)) return QNAN;
        if (is_inf(a) || is_inf(b)) begin
            if ((!is_inf(a) && ma == 11'd0) || (!is_inf(b) && mb == 11'd0)) return QNAN;
            return {s, INF_MAG};
        end
        if (ma == 11'd0 || mb == 11'd0) return {s, 15'd0};
        return round_pack(s, 48'(ma) * 48'(mb), ea + eb - 50);
    endfunction

    function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
        logic [10:0] ma, mb, ml, ms;
        int          ea, eb, el, es;
        logic        sl, ss;
        logic [47:0] m;
        unpack(a, ma, ea);
        unpack(b, mb, eb);
        if (is_nan(a) || is_nan(b)) return QNAN;
        if (is_inf(a) && is_inf(b) && (a[15] != b[15])) return QNAN;
        if (is_inf(a)) return a;
        if (is_inf(b)) return b;
        if (ma == 11'd0 && mb == 11'd0) return {a[15] & b[15], 15'd0};
        if ((ea > eb) || ((ea == eb) && (ma >= mb))) begin
            sl = a[15]; ml = ma; el = ea;
            ss = b[15]; ms = mb; es = eb;
        end else begin
            sl = b[15]; ml = mb; el = eb;
            ss = a[15]; ms = ma; es = ea;
        end
        // Align exactly to the smaller operand's scale; the window is wide enough for any gap.
        if (sl == ss) m = (48'(ml) << (el - es)) + 48'(ms);
        else          m = (48'(ml) << (el - es)) - 48'(ms);
        if (m == 48'd0) return 16'h0000;
        return round_pack(sl, m, es - 25);
    endfunction

    // Transposed-form datapath: one multiply and one add per tap between registers.
    always_comb begin
        s0_nxt_c = fp_mul(X_i, w0);
        s1_nxt_c = fp_add(s0, fp_mul(X_i, w1));
        s2_nxt_c = fp_add(s1, fp_mul(X_i, w2));
        s3_nxt_c = fp_add(s2, fp_mul(X_i, w3));
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            w0      <= 16'h0000;
            w1      <= 16'h0000;
            w2      <= 16'h0000;
            w3      <= 16'h0000;
            s0      <= 16'h0000;
            s1      <= 16'h0000;
            s2      <= 16'h0000;
            s3      <= 16'h0000;
            fc      <= 3'd0;
            valid_o <= 1'b0;
        end else begin
            if (enW[3]) w0 <= W_i;
            if (enW[2]) w1 <= W_i;
            if (enW[1]) w2 <= W_i;
            if (enW[0]) w3 <= W_i;
            if (enX) begin
                s0 <= s0_nxt_c;
                s1 <= s1_nxt_c;
                s2 <= s2_nxt_c;
                s3 <= s3_nxt_c;
            end
            // A weight load restarts the window even if a sample is taken on the same edge.
            if (enW != 4'd0) begin
                fc      <= 3'd0;
                valid_o <= 1'b0;
            end else if (enX) begin
                fc      <= (fc == 3'(FILL_FULL)) ? fc : fc + 3'd1;
                valid_o <= (fc >= 3'(FILL_FULL - 1));
            end else begin
                valid_o <= 1'b0;
            end
        end
    end

    assign Y_o = s3;

endmodule

// File: tb/tb_mac_row4.sv
// tb_mac_row4: directed vectors for mac_row4 with a per-edge expectation queue and an independent monitor.
module tb_mac_row4;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        enX = 1'b0;
    logic [3:0]  enW = 4'd0;
    logic [15:0] X_i = 16'h0000;
    logic [15:0] W_i = 16'h0000;
    logic        valid_o;
    logic [15:0] Y_o;

    typedef struct {
        logic        v;
        logic [15:0] y;
        string       nm;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    int   total = 0;
    int   bad = 0;

`ifdef MAC_ROW4_SUBNORM_EN
    localparam logic [15:0] SUB_Y = 16'h008F;
`else
    localparam logic [15:0] SUB_Y = 16'h0000;
`endif

    mac_row4 dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enX     (enX),
        .enW     (enW),
        .X_i     (X_i),
        .W_i     (W_i),
        .valid_o (valid_o),
        .Y_o     (Y_o)
    );

    always #5 clk = ~clk;

    // Monitor: one expectation per active edge, checked just after the edge.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() != 0) begin
            cur = sb_q.pop_front();
            total++;
            if (valid_o !== cur.v) begin
                bad++;
                $display("FAIL %s valid_o got=%0b want=%0b", cur.nm, valid_o, cur.v);
            end
            total++;
            if (Y_o !== cur.y) begin
                bad++;
                $display("FAIL %s Y_o got=%h want=%h", cur.nm, Y_o, cur.y);
            end
        end
    end

    task automatic step(input logic rst, input logic ex, input logic [3:0] ew,
                        input logic [15:0] x, input logic [15:0] w,
                        input logic ev, input logic [15:0] ey, input string nm);
        @(negedge clk);
        reset_n = rst;
        enX     = ex;
        enW     = ew;
        X_i     = x;
        W_i     = w;
        sb_q.push_back('{v: ev, y: ey, nm: nm});
        @(posedge clk);
    endtask

    task automatic load_window_weights();
        step(1'b0, 1'b0, 4'b1000, 16'h0, 16'h34CC, 1'b0, 16'h0000, "ld_w0");
        step(1'b0, 1'b0, 4'b0100, 16'h0, 16'hB800, 1'b0, 16'h0000, "ld_w1");
        step(1'b0, 1'b0, 4'b0010, 16'h0, 16'h3ECC, 1'b0, 16'h0000, "ld_w2");
        step(1'b0, 1'b0, 4'b0001, 16'h0, 16'h4366, 1'b0, 16'h0000, "ld_w3");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset overrides an active sample stream
        step(1'b1, 1'b1, 4'd0, 16'h3C00, 16'h0, 1'b0, 16'h0000, "rst0");
        step(1'b1, 1'b1, 4'd0, 16'h3C00, 16'h0, 1'b0, 16'h0000, "rst1");

        // Window sum with unit samples: partial chain 0x4366, 0x4566, 0x44E6, 0x4533
        load_window_weights();
        step(1'b0, 1'b1, 4'd0, 16'h3C00, 16'h0, 1'b0, 16'h4366, "win1");
        step(1'b0, 1'b1, 4'd0, 16'h3C00, 16'h0, 1'b0, 16'h4566, "win2");
        step(1'b0, 1'b1, 4'd0, 16'h3C00, 16'h0, 1'b0, 16'h44E6, "win3");
        step(1'b0, 1'b1, 4'd0, 16'h3C00, 16'h0, 1'b1, 16'h4533, "win4");

        // Overflow to +Inf
        step(1'b1, 1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 16'h0000, "rst_ovf");
        load_window_weights();
        step(1'b0, 1'b1, 4'd0, 16'h7BFF, 16'h0, 1'b0, 16'h7C00, "ovf1");
        step(1'b0, 1'b1, 4'd0, 16'h7BFF, 16'h0, 1'b0, 16'h7C00, "ovf2");
        step(1'b0, 1'b1, 4'd0, 16'h7BFF, 16'h0, 1'b0, 16'h7C00, "ovf3");
        step(1'b0, 1'b1, 4'd0, 16'h7BFF, 16'h0, 1'b1, 16'h7C00, "ovf4");

        // Gap after sample 2 holds Y and drops valid only for the gap
        step(1'b1, 1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 16'h0000, "rst_gap");
        load_window_weights();
        step(1'b0, 1'b1, 4'd0, 16'h3C00, 16'h0, 1'b0, 16'h4366, "gap_s1");
        step(1'b0, 1'b1, 4'd0, 16'h3C00, 16'h0, 1'b0, 16'h4566, "gap_s2");
        step(1'b0, 1'b0, 4'd0, 16'h1234, 16'h0, 1'b0, 16'h4566, "gap_hold");
        step(1'b0, 1'b1, 4'd0, 16'h3C00, 16'h0, 1'b0, 16'h44E6, "gap_s3");
        step(1'b0, 1'b1, 4'd0, 16'h3C00, 16'h0, 1'b1, 16'h4533, "gap_s4");
        step(1'b0, 1'b1, 4'd0, 16'h3C00, 16'h0, 1'b1, 16'h4533, "gap_s5");

        // Reload W3=0 with a same-edge sample: old W3 used, window restarts
        step(1'b0, 1'b1, 4'b0001, 16'h3C00, 16'h0000, 1'b0, 16'h4533, "reload");
        step(1'b0, 1'b1, 4'd0, 16'h3C00, 16'h0, 1'b0, 16'h3DFF, "rl_s1");
        step(1'b0, 1'b1, 4'd0, 16'h3C00, 16'h0, 1'b0, 16'h3DFF, "rl_s2");
        step(1'b0, 1'b1, 4'd0, 16'h3C00, 16'h0, 1'b0, 16'h3DFF, "rl_s3");
        step(1'b0, 1'b1, 4'd0, 16'h3C00, 16'h0, 1'b1, 16'h3DFF, "rl_s4");

        // Inf*0 gives canonical NaN; the Inf then propagates down the chain
        step(1'b0, 1'b1, 4'd0, 16'h7C00, 16'h0, 1'b1, 16'h7E00, "inf_x_zero");
        step(1'b0, 1'b1, 4'd0, 16'h3C00, 16'h0, 1'b1, 16'h7C00, "inf_prop");

        // Subnormal sample through a unit weight
        step(1'b1, 1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 16'h0000, "rst_sub");
        step(1'b0, 1'b0, 4'b0001, 16'h0, 16'h3C00, 1'b0, 16'h0000, "ld_sub");
        step(1'b0, 1'b1, 4'd0, 16'h008F, 16'h0, 1'b0, SUB_Y, "sub1");
        step(1'b0, 1'b1, 4'd0, 16'h008F, 16'h0, 1'b0, SUB_Y, "sub2");
        step(1'b0, 1'b1, 4'd0, 16'h008F, 16'h0, 1'b0, SUB_Y, "sub3");
        step(1'b0, 1'b1, 4'd0, 16'h008F, 16'h0, 1'b1, SUB_Y, "sub4");

        // Mid-stream reset discards the window
        step(1'b1, 1'b1, 4'd0, 16'h3C00, 16'h0, 1'b0, 16'h0000, "rst_mid");
        step(1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 16'h0000, "idle");

        repeat (2) @(posedge clk);
        #2;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
